// File: rtl/char_buf_arb.sv
// char_buf_arb: 16x16 character buffer with a two-requester write arbiter and optional clear sequencer
// Ports: clk, rst_n (async, active-low); a_req/a_xy/a_code/a_gnt and b_req/b_xy/b_code/b_gnt
// write requesters; clr_req/busy clear-screen control; rd_xy/rd_code combinational read port.
// Macro CHAR_BUF_CLEAR_EN compiles in the clear sequencer; without it clr_req is ignored.
module char_buf_arb #(
  parameter logic [6:0] CLEAR_CODE = 7'h20,
  parameter int CELLS = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic [7:0] a_xy,
  input  logic [6:0] a_code,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [7:0] b_xy,
  input  logic [6:0] b_code,
  output logic       b_gnt,
  input  logic       clr_req,
  output logic       busy,
  input  logic [7:0] rd_xy,
  output logic [6:0] rd_code
);
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q;
  logic [7:0] cnt_q;
  logic clr_go, idle_ok, last_b_q, last_b_d, we;
  logic [7:0] wa;
  logic [6:0] wd;
  logic [6:0] mem_q [CELLS];
`ifdef CHAR_BUF_CLEAR_EN
  state_e state_d;
  logic [7:0] cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (clr_req) begin
        state_d = CLEAR;
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'(CELLS - 1)) state_d = IDLE;
    end
  end
  assign clr_go = state_q == IDLE && clr_req;
`else
  assign state_q = IDLE;
  assign cnt_q = '0;
  assign clr_go = 1'b0 & clr_req;
`endif
  assign busy = state_q == CLEAR;
  // A clear request in IDLE suppresses both grants for that cycle
  assign idle_ok = rst_n && state_q == IDLE && !clr_go;
  // last_b_q set means B won last, so A takes the next contention
  assign a_gnt = idle_ok && a_req && (!b_req || last_b_q);
  assign b_gnt = idle_ok && b_req && !(a_req && last_b_q);
  assign last_b_d = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_b_q;
  assign we = busy || a_gnt || b_gnt;
  assign wa = busy ? cnt_q : a_gnt ? a_xy : b_xy;
  assign wd = busy ? CLEAR_CODE : a_gnt ? a_code : b_code;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_b_q <= 1'b1;
    else last_b_q <= last_b_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < CELLS; i++) mem_q[i] <= CLEAR_CODE;
    else if (we) mem_q[wa] <= wd;
  end
  assign rd_code = mem_q[rd_xy];
endmodule
